imem_server: RTL and testbench
==============================

IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of the instruction array (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT, default 2, range 0..7, meaning wait cycles inserted between accept and response.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  fetch request from the fetch stage.
REQ-006 SHALL have port addr  input  32  byte address of the requested instruction.
REQ-007 SHALL have port gnt  output  1  request accepted this cycle.
REQ-008 SHALL have port rvalid  output  1  response valid, single-cycle pulse.
REQ-009 SHALL have port rdata  output  32  instruction word returned with rvalid.
REQ-010 SHALL have port err  output  1  response error, qualified by rvalid.
REQ-011 SHALL have port busy  output  1  request outstanding (not IDLE).
REQ-012 SHALL have port ld_we  input  1  loader write enable.
REQ-013 SHALL have port ld_addr  input  ADDR_W  loader word address.
REQ-014 SHALL have port ld_data  input  32  loader write data.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 gnt SHALL be combinational: 1 iff state==IDLE and req==1 and ld_we==0.
REQ-017 On an accept edge (gnt==1) SHALL latch addr and go to WAIT with wait counter = WAIT-1, or directly to RESP when WAIT==0.
REQ-018 In WAIT SHALL decrement counter each cycle; at counter==0 SHALL go to RESP on next edge.
REQ-019 rvalid SHALL be 1 for exactly one cycle (state RESP), WAIT+1 cycles after the accept edge; RESP SHALL always return to IDLE.
REQ-020 No new request SHALL be granted in WAIT or RESP; req held high SHALL be granted in the IDLE cycle following RESP (max throughput one word per WAIT+2 cycles).
REQ-021 rdata SHALL be registered, sampled from array word latched_addr[ADDR_W+1:2] on the edge entering RESP; a loader write to that word on the same edge SHALL return the old data (read-before-write).
REQ-022 If latched_addr[31:ADDR_W+2] != 0, response SHALL have err=1 and rdata=0.
REQ-023 rdata and err SHALL hold their values outside RESP until the next response; consumers SHALL qualify with rvalid.
REQ-024 ld_we SHALL write ld_data to array[ld_addr] on the rising edge in any state; in IDLE it SHALL block gnt that cycle (loader priority).
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 rst high at an edge SHALL force state IDLE, counter 0, rvalid 0, err 0, rdata 0, busy 0, regardless of state; an outstanding request SHALL be dropped with no response.
REQ-027 Array contents SHALL NOT be reset; a loader write coinciding with rst SHALL still be performed.

Configuration
REQ-028 With macro IMEM_ALIGN_CHK_EN defined, latched_addr[1:0] != 0 SHALL produce err=1, rdata=0 in addition to REQ-022.
REQ-029 Without IMEM_ALIGN_CHK_EN, addr[1:0] SHALL be ignored and never cause err.

Verification
REQ-030 Load array[3]=0x2408_0005, WAIT=2, req with addr=0x0000_000C -> gnt at cycle 0, rvalid=1 at cycle 3 with rdata=0x2408_0005, err=0.
REQ-031 WAIT=0, req held high, addr=0x0,0x4 -> gnt at cycles 0 and 2, rvalid at cycles 1 and 3, busy=1 exactly in cycles 1 and 3.
REQ-032 ADDR_W=10, addr=0x0000_1000 -> rvalid with err=1, rdata=0x0000_0000.
REQ-033 addr=0x0000_0006 -> err=1 with IMEM_ALIGN_CHK_EN, err=0 and rdata=array[1] without.
REQ-034 ld_we=1 and req=1 together in IDLE -> gnt=0 that cycle, write done, gnt=1 next cycle; loader write to array[3] on edge entering RESP -> old word returned.
REQ-035 rst asserted during WAIT -> next cycle IDLE, busy=0, no rvalid ever issued for that request, next req granted normally.

Source files
------------

// File: rtl/imem_server.sv
// Instruction memory server: single-outstanding fetch port with WAIT-cycle latency plus a loader write port.
// Optional misaligned-fetch error reporting is enabled by defining IMEM_ALIGN_CHK_EN.
module imem_server #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       addr,
    output logic              gnt,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [2:0] WAIT_INIT = 3'(WAIT - 1);
    localparam int         DEPTH = 1 << ADDR_W;

    // Flags fetch addresses beyond the array (and, optionally, misaligned ones).
    function automatic logic addr_err(input logic [31:0] a);
        logic e;
        e = ((a >> (ADDR_W + 2)) != 32'd0);
`ifdef IMEM_ALIGN_CHK_EN
        e = e | (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    logic [31:0] mem_r [0:DEPTH-1];
    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic [2:0]  cnt_r;
    logic [2:0]  next_cnt_s;
    logic [31:0] addr_r;
    logic [31:0] resp_addr_s;
    logic        gnt_s;
    logic        enter_resp_s;
    logic        resp_err_s;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        err_r;

    // Grant and next-state/counter decode.
    always_comb begin
        gnt_s        = (state_r == S_IDLE) && req && !ld_we;
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (gnt_s) begin
                    if (WAIT == 0) begin
                        next_state_s = S_RESP;
                        next_cnt_s   = 3'd0;
                    end else begin
                        next_state_s = S_WAIT;
                        next_cnt_s   = WAIT_INIT;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == 3'd0) begin
                    next_state_s = S_RESP;
                end else begin
                    next_cnt_s = cnt_r - 3'd1;
                end
            end
            S_RESP: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
                next_cnt_s   = 3'd0;
            end
        endcase
    end

    // With zero wait the array is read on the accept edge, before addr is latched.
    always_comb begin
        enter_resp_s = (next_state_s == S_RESP) && (state_r != S_RESP);
        if (state_r == S_IDLE) begin
            resp_addr_s = addr;
        end else begin
            resp_addr_s = addr_r;
        end
        resp_err_s = addr_err(resp_addr_s);
    end

    // Control state, wait counter and latched fetch address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 3'd0;
            addr_r  <= 32'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            if (gnt_s) begin
                addr_r <= addr;
            end
        end
    end

    // Response registers; data and error hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= enter_resp_s;
            if (enter_resp_s) begin
                err_r <= resp_err_s;
                if (resp_err_s) begin
                    rdata_r <= 32'd0;
                end else begin
                    rdata_r <= mem_r[resp_addr_s[ADDR_W+1:2]];
                end
            end
        end
    end

    // Loader port; not reset so contents survive rst and writes proceed during it.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    assign gnt    = gnt_s;
    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign err    = err_r;
    assign busy   = (state_r != S_IDLE);

endmodule

// File: tb/tb_imem_server.sv
// Randomized self-checking bench for imem_server against a transaction-level model,
// plus directed scenarios and a zero-wait instance for back-to-back throughput.
module tb_imem_server;

    localparam int TB_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst, req, ld_we;
    logic [31:0] addr, ld_data;
    logic [9:0]  ld_addr;
    logic        gnt, rvalid, err, busy;
    logic [31:0] rdata;

    logic        rst0, req0, ld_we0;
    logic [31:0] addr0, ld_data0;
    logic [3:0]  ld_addr0;
    logic        gnt0, rvalid0, err0, busy0;
    logic [31:0] rdata0;

    int n_checks = 0;
    int n_errors = 0;

    // Model: memory image plus at most one pending fetch with cycles-to-response.
    logic [31:0] mem_m [0:1023];
    bit          pend;
    int          rem;
    logic [31:0] p_addr;
    logic [31:0] m_rdata;
    bit          m_err;
    logic        obs_gnt, obs_rvalid, obs_err, obs_busy;
    logic [31:0] obs_rdata;

    imem_server #(.ADDR_W(10), .WAIT(TB_WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .err(err), .busy(busy), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    imem_server #(.ADDR_W(4), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .addr(addr0), .gnt(gnt0), .rvalid(rvalid0),
        .rdata(rdata0), .err(err0), .busy(busy0), .ld_we(ld_we0), .ld_addr(ld_addr0),
        .ld_data(ld_data0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        bit b;
        b = (a[31:12] != 20'd0);
`ifdef IMEM_ALIGN_CHK_EN
        b = b | (a[1:0] != 2'b00);
`endif
        return b;
    endfunction

    task automatic capture();
        m_err   = addr_bad(p_addr);
        m_rdata = m_err ? 32'd0 : mem_m[p_addr[11:2]];
    endtask

    // One clock cycle on the main instance: drive, check against model, advance model.
    task automatic step(input bit r, input bit rq, input logic [31:0] a, input bit we,
                        input logic [9:0] la, input logic [31:0] ld);
        bit acc;
        @(negedge clk);
        rst = r; req = rq; addr = a; ld_we = we; ld_addr = la; ld_data = ld;
        #1;
        acc = !pend && rq && !we;
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata; obs_err = err; obs_busy = busy;
        check_val("gnt", {31'd0, gnt}, {31'd0, acc});
        check_val("busy", {31'd0, busy}, {31'd0, pend});
        check_val("rvalid", {31'd0, rvalid}, {31'd0, (pend && rem == 0)});
        check_val("rdata", rdata, m_rdata);
        check_val("err", {31'd0, err}, {31'd0, m_err});
        @(posedge clk);
        if (r) begin
            pend = 1'b0; rem = 0; m_rdata = 32'd0; m_err = 1'b0;
        end else if (pend) begin
            if (rem == 0) begin
                pend = 1'b0;
            end else begin
                rem--;
                if (rem == 0) capture();
            end
        end else if (acc) begin
            pend = 1'b1; p_addr = a; rem = TB_WAIT;
            if (rem == 0) capture();
        end
        if (we) mem_m[la] = ld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
    endtask

    // One clock cycle on the zero-wait instance; checks are done by the caller.
    task automatic step0(input bit rq, input logic [31:0] a, input bit we,
                         input logic [3:0] la, input logic [31:0] ld);
        @(negedge clk);
        rst0 = 1'b0; req0 = rq; addr0 = a; ld_we0 = we; ld_addr0 = la; ld_data0 = ld;
        #1;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; req = 1'b0; addr = 32'd0; ld_we = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
        rst0 = 1'b1; req0 = 1'b0; addr0 = 32'd0; ld_we0 = 1'b0; ld_addr0 = 4'd0; ld_data0 = 32'd0;
        pend = 1'b0; rem = 0; p_addr = 32'd0; m_rdata = 32'd0; m_err = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state is checked inside the first steps; preload words 0..15.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 10'(i), $urandom);

        // Basic fetch with WAIT=2.
        step(1'b0, 1'b0, 32'd0, 1'b1, 10'd3, 32'h2408_0005);
        step(1'b0, 1'b1, 32'h0000_000C, 1'b0, 10'd0, 32'd0);
        check_val("r030_gnt", {31'd0, obs_gnt}, 32'd1);
        idle(2);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        check_val("r030_rvalid", {31'd0, obs_rvalid}, 32'd1);
        check_val("r030_rdata", obs_rdata, 32'h2408_0005);
        check_val("r030_err", {31'd0, obs_err}, 32'd0);

        // Out-of-range address.
        step(1'b0, 1'b1, 32'h0000_1000, 1'b0, 10'd0, 32'd0);
        idle(2);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        check_val("r032_rvalid", {31'd0, obs_rvalid}, 32'd1);
        check_val("r032_err", {31'd0, obs_err}, 32'd1);
        check_val("r032_rdata", obs_rdata, 32'd0);

        // Misaligned address.
        step(1'b0, 1'b1, 32'h0000_0006, 1'b0, 10'd0, 32'd0);
        idle(2);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
`ifdef IMEM_ALIGN_CHK_EN
        check_val("r033_err", {31'd0, obs_err}, 32'd1);
        check_val("r033_rdata", obs_rdata, 32'd0);
`else
        check_val("r033_err", {31'd0, obs_err}, 32'd0);
        check_val("r033_rdata", obs_rdata, mem_m[1]);
`endif

        // Loader priority, then write on the edge entering RESP returns old data.
        step(1'b0, 1'b1, 32'h0000_000C, 1'b1, 10'd5, 32'h1111_2222);
        check_val("r034_blocked", {31'd0, obs_gnt}, 32'd0);
        step(1'b0, 1'b1, 32'h0000_000C, 1'b0, 10'd0, 32'd0);
        check_val("r034_gnt", {31'd0, obs_gnt}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 10'd3, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        check_val("r034_old", obs_rdata, 32'h2408_0005);
        step(1'b0, 1'b1, 32'h0000_0014, 1'b0, 10'd0, 32'd0);
        idle(2);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        check_val("r034_ldw", obs_rdata, 32'h1111_2222);

        // Reset during WAIT drops the request.
        step(1'b0, 1'b1, 32'h0000_0008, 1'b0, 10'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0);
        check_val("r035_busy", {31'd0, obs_busy}, 32'd0);
        check_val("r035_rvalid", {31'd0, obs_rvalid}, 32'd0);
        idle(3);
        step(1'b0, 1'b1, 32'h0000_0008, 1'b0, 10'd0, 32'd0);
        check_val("r035_regnt", {31'd0, obs_gnt}, 32'd1);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = (32'($urandom_range(1, 1023)) << 12) | 32'($urandom_range(0, 63));
            end else begin
                a = 32'($urandom_range(0, 63));
            end
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7), a,
                 ($urandom_range(0, 4) == 0), 10'($urandom_range(0, 15)), $urandom);
        end

        // Zero-wait instance: back-to-back grants every second cycle.
        step0(1'b0, 32'd0, 1'b1, 4'd0, 32'hA0A0_0000);
        step0(1'b0, 32'd0, 1'b1, 4'd1, 32'hB1B1_0001);
        step0(1'b1, 32'h0000_0000, 1'b0, 4'd0, 32'd0);
        check_val("w0_c0_gnt", {31'd0, gnt0}, 32'd1);
        check_val("w0_c0_busy", {31'd0, busy0}, 32'd0);
        step0(1'b1, 32'h0000_0004, 1'b0, 4'd0, 32'd0);
        check_val("w0_c1_gnt", {31'd0, gnt0}, 32'd0);
        check_val("w0_c1_busy", {31'd0, busy0}, 32'd1);
        check_val("w0_c1_rvalid", {31'd0, rvalid0}, 32'd1);
        check_val("w0_c1_rdata", rdata0, 32'hA0A0_0000);
        step0(1'b1, 32'h0000_0004, 1'b0, 4'd0, 32'd0);
        check_val("w0_c2_gnt", {31'd0, gnt0}, 32'd1);
        check_val("w0_c2_busy", {31'd0, busy0}, 32'd0);
        check_val("w0_c2_rvalid", {31'd0, rvalid0}, 32'd0);
        step0(1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        check_val("w0_c3_busy", {31'd0, busy0}, 32'd1);
        check_val("w0_c3_rvalid", {31'd0, rvalid0}, 32'd1);
        check_val("w0_c3_rdata", rdata0, 32'hB1B1_0001);
        check_val("w0_c3_err", {31'd0, err0}, 32'd0);
        step0(1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        check_val("w0_c4_busy", {31'd0, busy0}, 32'd0);
        check_val("w0_c4_rvalid", {31'd0, rvalid0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
